// File: rtl/pipe_skid_register.sv
// Pipeline stage register with valid/ready on both sides and a two-entry skid buffer.
// Optional saturating back-pressure counter: define STALL_COUNTER_EN to build it.
module pipe_skid_register #(
  parameter int DATA_WIDTH      = 32,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      default_data,
  input  logic                       flush,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [STALL_CNT_WIDTH-1:0] stall_count
);

  // Handshake: a word moves on a side only in a cycle where that side's valid
  // and ready are both high at the rising edge; valid never depends on ready.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] main_q;
  logic [DATA_WIDTH-1:0] skid_q;
  logic                  in_fire;
  logic                  out_fire;

  // Both outputs decode straight from the state flop, so in_ready has no
  // combinational path from out_ready.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state  <= EMPTY;
      main_q <= default_data;
      skid_q <= default_data;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_q <= in_data;
            state  <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (in_fire) begin
            skid_q <= in_data;
            state  <= TWO;
          end else if (out_fire) begin
            state  <= EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            main_q <= skid_q;
            state  <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef STALL_COUNTER_EN
  logic [STALL_CNT_WIDTH-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != {STALL_CNT_WIDTH{1'b1}})) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_register.sv
// Directed bench for pipe_skid_register: streaming, back-pressure, flush, reset, stall counter.
module tb_pipe_skid_register;

  localparam int DW = 32;
  localparam int SW = 4;

  logic          clk;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] default_data;
  logic          flush;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] stall_count;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  pipe_skid_register #(
    .DATA_WIDTH     (DW),
    .STALL_CNT_WIDTH(SW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .default_data(default_data),
    .flush       (flush),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .stall_count (stall_count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Expected stall count: only meaningful when the counter is built.
  function automatic logic [DW-1:0] exp_stall(input int n);
`ifdef STALL_COUNTER_EN
    return DW'(n);
`else
    return '0;
`endif
  endfunction

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [DW-1:0] d);
    in_valid = v;
    in_data  = d;
  endtask

  task automatic check_idle(input string tag, input logic [DW-1:0] data_exp);
    check({tag, "_out_valid"}, DW'(out_valid), 0);
    check({tag, "_out_data"}, out_data, data_exp);
    check({tag, "_in_ready"}, DW'(in_ready), 1);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    default_data = '0;
    drive_in(1'b0, '0);
    step();
    check_idle("reset", 32'h0);
    check("reset_stall", DW'(stall_count), 0);
    reset = 1'b0;

    // Stream 1,2,3 with downstream always ready.
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive_in(1'b1, DW'(i));
      exp_q.push_back(DW'(i));
      step();
      check("stream_valid", DW'(out_valid), 1);
      check("stream_data", out_data, exp_q.pop_front());
      check("stream_in_ready", DW'(in_ready), 1);
    end
    drive_in(1'b0, '0);
    step();
    check("stream_drained_valid", DW'(out_valid), 0);
    check("stream_last_held", out_data, 32'h3);

    // Back-pressure: fill main then skid.
    out_ready = 1'b0;
    drive_in(1'b1, 32'hA);
    step();
    check("bp_a_data", out_data, 32'hA);
    check("bp_a_in_ready", DW'(in_ready), 1);
    drive_in(1'b1, 32'hB);
    step();
    check("bp_two_in_ready", DW'(in_ready), 0);
    check("bp_two_data", out_data, 32'hA);
    drive_in(1'b1, 32'hD);
    step();
    check("bp_no_accept_data", out_data, 32'hA);
    check("bp_stall", DW'(stall_count), exp_stall(2));
    drive_in(1'b0, '0);
    out_ready = 1'b1;
    step();
    check("bp_drain_b", out_data, 32'hB);
    check("bp_drain_valid", DW'(out_valid), 1);
    check("bp_in_ready_back", DW'(in_ready), 1);
    step();
    check("bp_empty", DW'(out_valid), 0);
    check("bp_stall_hold", DW'(stall_count), exp_stall(2));

    // Flush while TWO.
    out_ready = 1'b0;
    drive_in(1'b1, 32'hA);
    step();
    drive_in(1'b1, 32'hB);
    step();
    check("fl_two_in_ready", DW'(in_ready), 0);
    check("fl_stall_before", DW'(stall_count), exp_stall(3));
    drive_in(1'b0, '0);
    flush = 1'b1;
    default_data = 32'h20;
    step();
    flush = 1'b0;
    check_idle("flush", 32'h20);
    check("flush_stall", DW'(stall_count), 0);
    out_ready = 1'b1;
    step();
    check("flush_no_b", DW'(out_valid), 0);

    // Flush with simultaneous in_fire discards the word.
    drive_in(1'b1, 32'hC);
    flush = 1'b1;
    default_data = 32'h55;
    step();
    flush = 1'b0;
    drive_in(1'b0, '0);
    check_idle("flush_in", 32'h55);
    step();
    check("flush_in_dropped", DW'(out_valid), 0);

    // Reset mid-stream while TWO.
    out_ready = 1'b0;
    drive_in(1'b1, 32'h11);
    step();
    drive_in(1'b1, 32'h22);
    step();
    drive_in(1'b0, '0);
    check("rst_two_in_ready", DW'(in_ready), 0);
    check("rst_stall_before", DW'(stall_count), exp_stall(1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle("rst_mid", 32'h0);
    check("rst_mid_stall", DW'(stall_count), 0);

    // Saturation: 20 stalled edges on a 4-bit counter.
    drive_in(1'b1, 32'h77);
    step();
    drive_in(1'b0, '0);
    check("sat_start", DW'(stall_count), 0);
    repeat (20) step();
    check("sat_count", DW'(stall_count), exp_stall(15));
    check("sat_data_held", out_data, 32'h77);
    flush = 1'b1;
    default_data = 32'h0;
    step();
    flush = 1'b0;
    check("sat_flush_clear", DW'(stall_count), 0);
    check("sat_flush_valid", DW'(out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
